// File: rtl/counter_drv_pkg.sv
// counter_drv_pkg: shared types and constants for the counter command driver.
//   cmd_op_e    - command opcodes carried on the command port
//   drv_state_e - driver FSM states
//   cmd_t       - one queued command (op, load data, burst length)
package counter_drv_pkg;

    localparam int CMD_DATA_W = 8;
    localparam int CMD_LEN_W  = 8;

    localparam logic [7:0] OVF_TOTAL_MAX = 8'd255;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        REPORT = 2'd3
    } drv_state_e;

    typedef struct packed {
        cmd_op_e                op;
        logic [CMD_DATA_W-1:0]  data;
        logic [CMD_LEN_W-1:0]   len;
    } cmd_t;

endpackage

// File: rtl/counter_cmd_driver_if.sv
// counter_cmd_driver_if: command request and response bundle of the driver.
//   master - test/control logic: drives commands, receives responses
//   slave  - counter_cmd_driver: accepts commands, returns responses
interface counter_cmd_driver_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic [1:0]        cmd_op_in;
    logic [DATA_W-1:0] cmd_data_in;
    logic [LEN_W-1:0]  cmd_len_in;
    logic              rsp_valid_out;
    logic [DATA_W-1:0] rsp_val_out;
    logic              rsp_ovf_out;

    modport master (
        output cmd_valid_in, cmd_op_in, cmd_data_in, cmd_len_in,
        input  cmd_ready_out, rsp_valid_out, rsp_val_out, rsp_ovf_out
    );

    modport slave (
        input  cmd_valid_in, cmd_op_in, cmd_data_in, cmd_len_in,
        output cmd_ready_out, rsp_valid_out, rsp_val_out, rsp_ovf_out
    );
endinterface

// File: rtl/cnt_cmd_fifo.sv
// cnt_cmd_fifo: synchronous FIFO of cmd_t with a registered occupancy count.
//   clk_in, nrst_in - clock, async active-low reset (pointers/count only)
//   push, din       - write when push (caller guarantees !full)
//   pop, dout       - head is always visible on dout; pop advances it
//   full, empty, count - status derived from the registered count
module cnt_cmd_fifo
    import counter_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   nrst_in,
    input  logic                   push,
    input  cmd_t                   din,
    input  logic                   pop,
    output cmd_t                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
endmodule

// File: rtl/counter_cmd_driver.sv
// counter_cmd_driver: transaction front end for an up/down counter.
//   clk_in, nrst_in       - clock, async active-low reset
//   cmd (slave)           - command valid/ready port and one-cycle response
//   en/set/up_ctrl_out,
//   load_val_out          - registered control pins to the counter
//   cnt_val_in, ovf_in    - counter value and overflow observed back
//   ovf_total_out         - saturating count of commands that overflowed
//   busy_out              - FSM active or commands still queued
// Optional: define CNT_DRV_ABORT_EN to add abort_in, which cuts an
// UP/DOWN burst short after the current issue cycle.
// cmd_t is sized by the package; DATA_W/LEN_W must match its widths.
module counter_cmd_driver
    import counter_drv_pkg::*;
#(
    parameter int DATA_W     = CMD_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = CMD_LEN_W
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    counter_cmd_driver_if.slave  cmd,
    output logic                 en_ctrl_out,
    output logic                 set_ctrl_out,
    output logic                 up_ctrl_out,
    output logic [DATA_W-1:0]    load_val_out,
    input  logic [DATA_W-1:0]    cnt_val_in,
    input  logic                 ovf_in,
    output logic [7:0]           ovf_total_out,
    output logic                 busy_out
`ifdef CNT_DRV_ABORT_EN
    ,
    input  logic                 abort_in
`endif
);
    localparam logic [$clog2(FIFO_DEPTH):0] FULL_CNT = ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);

    cmd_t                        fifo_din, head;
    logic                        push, pop, full, empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    drv_state_e        state_q, state_d;
    cmd_op_e           op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  burst_q, burst_d;
    logic              sticky_q, rsp_valid_q, last, abort, issue_d;
    logic [7:0]        total_q;

`ifdef CNT_DRV_ABORT_EN
    assign abort = abort_in;
`else
    assign abort = 1'b0;
`endif

    // Ready comes from the registered count only, so a full FIFO never
    // takes a push in the same cycle it pops.
    assign cmd.cmd_ready_out = (fifo_count != FULL_CNT);
    assign push              = cmd.cmd_valid_in && !full;
    assign fifo_din          = '{op:   cmd_op_e'(cmd.cmd_op_in),
                                 data: cmd.cmd_data_in,
                                 len:  cmd.cmd_len_in};

    cnt_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .push    (push),
        .din     (fifo_din),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        burst_d = burst_q;
        pop     = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                op_d    = head.op;
                data_d  = head.data;
                burst_d = (head.len == '0) ? LEN_W'(1) : head.len;
                state_d = ISSUE;
            end
            ISSUE: begin
                // LOAD and NOP are single-cycle; counting ops run the burst.
                last    = (op_q == OP_LOAD) || (op_q == OP_NOP) ||
                          (burst_q <= LEN_W'(1)) || abort;
                burst_d = burst_q - LEN_W'(1);
                if (last) state_d = SETTLE;
            end
            SETTLE:  state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controls are registered off the next state, so they are high exactly
    // while the FSM sits in ISSUE. LOAD raises en too so an en-gated
    // counter still takes the load.
    assign issue_d = (state_d == ISSUE);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q      <= IDLE;
            op_q         <= OP_NOP;
            data_q       <= '0;
            burst_q      <= '0;
            sticky_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            total_q      <= '0;
            en_ctrl_out  <= 1'b0;
            set_ctrl_out <= 1'b0;
            up_ctrl_out  <= 1'b0;
            load_val_out <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            burst_q      <= burst_d;
            rsp_valid_q  <= (state_d == REPORT);
            en_ctrl_out  <= issue_d && (op_d != OP_NOP);
            set_ctrl_out <= issue_d && (op_d == OP_LOAD);
            up_ctrl_out  <= issue_d && (op_d == OP_UP);
            load_val_out <= (issue_d && (op_d == OP_LOAD)) ? data_d : '0;

            if (pop)
                sticky_q <= 1'b0;
            else if (state_q == ISSUE || state_q == SETTLE)
                sticky_q <= sticky_q | ovf_in;

            if (state_q == REPORT && sticky_q && total_q != OVF_TOTAL_MAX)
                total_q <= total_q + 8'd1;
        end
    end

    // Counter output is stable from SETTLE on, so it is passed straight
    // through in the REPORT cycle.
    assign cmd.rsp_valid_out = rsp_valid_q;
    assign cmd.rsp_val_out   = rsp_valid_q ? cnt_val_in : '0;
    assign cmd.rsp_ovf_out   = rsp_valid_q & sticky_q;
    assign ovf_total_out     = total_q;
    assign busy_out          = (state_q != IDLE) || !empty;
endmodule

// File: doc/counter_cmd_driver.md
Name: counter_cmd_driver

Overview:
- Initiator side of the up/down counter control interface.
- Accepts queued commands over a valid/ready port and drives the counter's control pins: en, set, up and the load value.
- Observes the counter's value and overflow outputs, then returns one response per command: final value plus a sticky overflow flag.
- Sits between the test/control logic and the counter, so counter control is transaction-based rather than pin-level.

Parameters:
- DATA_W, 8: width of load value, counter value and response value.
- FIFO_DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- LEN_W, 8: width of the burst repeat count.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- nrst_in  input  1  asynchronous active-low reset.
- cmd_valid_in  input  1  command valid.
- cmd_ready_out  output  1  FIFO not full.
- cmd_op_in  input  2  operation: 0 NOP, 1 LOAD, 2 UP, 3 DOWN.
- cmd_data_in  input  DATA_W  load value; used by LOAD only.
- cmd_len_in  input  LEN_W  number of count cycles for UP/DOWN; 0 is treated as 1.
- en_ctrl_out  output  1  to counter en_ctrl_in.
- set_ctrl_out  output  1  to counter set_ctrl_in.
- up_ctrl_out  output  1  to counter up_ctrl_in.
- load_val_out  output  DATA_W  to counter counter_in.
- cnt_val_in  input  DATA_W  from counter counter_out.
- ovf_in  input  1  from counter ovf_out.
- rsp_valid_out  output  1  one-cycle response pulse.
- rsp_val_out  output  DATA_W  counter value sampled for the response.
- rsp_ovf_out  output  1  overflow seen during the command.
- ovf_total_out  output  8  saturating count of commands that overflowed.
- busy_out  output  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (async, nrst_in=0):
  - FIFO empty, FSM in IDLE, burst counter 0.
  - All outputs 0, except cmd_ready_out=1 once the FIFO is empty.
  - Reset mid-burst aborts immediately; no response is issued.
- FIFO accepts a command when cmd_valid_in && cmd_ready_out.
  - Simultaneous push and pop when full is not allowed; ready is computed from the registered count.
- FSM states: IDLE, ISSUE, SETTLE, REPORT.
- IDLE: if the FIFO is non-empty, pop the head into registers.
  - Clear the sticky overflow flag.
  - Load the burst counter with max(len,1).
  - Go to ISSUE the next cycle.
- ISSUE:
  - LOAD: set_ctrl_out=1, en_ctrl_out=1, load_val_out=data for exactly 1 cycle.
  - UP: en_ctrl_out=1, up_ctrl_out=1 for burst-count cycles.
  - DOWN: en_ctrl_out=1, up_ctrl_out=0 for burst-count cycles.
  - NOP: no control asserted, 1 cycle.
  - Control outputs are registered and change only on clk_in rising edges.
  - The last ISSUE cycle goes to SETTLE.
- SETTLE: exactly 1 cycle with all controls 0, covering the counter's 1-cycle registered output latency.
- REPORT: rsp_valid_out=1 for 1 cycle.
  - rsp_val_out=cnt_val_in sampled in this cycle.
  - rsp_ovf_out=sticky flag.
  - Return to IDLE; the next command may start the following cycle.
  - Minimum command period is 4 cycles.
- Sticky overflow = OR of ovf_in over the ISSUE and SETTLE cycles of the current command.
- ovf_total_out increments on a REPORT with rsp_ovf_out=1 and saturates at 255; it never wraps.
- No response backpressure; the consumer must accept the pulse.
- The driver assumes the counter gives set priority over count: LOAD asserts en as well, so a counter gated by en still loads.

Optional Feature:
- CNT_DRV_ABORT_EN defined:
  - Adds input abort_in (1 bit).
  - abort_in=1 during ISSUE ends the burst after the current cycle and moves to SETTLE.
  - The response is still issued, with rsp_ovf_out covering only the cycles actually issued.
  - abort_in is ignored in all other states.
- Undefined: no abort_in port; bursts always run to completion.

Decomposition:
- Package counter_drv_pkg:
  - typedef enum cmd_op_e {OP_NOP, OP_LOAD, OP_UP, OP_DOWN}.
  - typedef enum drv_state_e {IDLE, ISSUE, SETTLE, REPORT}.
  - Packed struct cmd_t {op, data, len}.
  - Constant OVF_TOTAL_MAX=255.
- Sub-module cnt_cmd_fifo: synchronous FIFO of cmd_t.
  - Ports: push, pop, full, empty, count.
  - Same clock and async active-low reset.

Test Plan:
- LOAD 0x10, then UP len 5 -> two responses: rsp_val 0x10, ovf 0; then 0x15, ovf 0. en high exactly 5 cycles in the second command.
- LOAD 0xFD, then UP len 4 -> second response rsp_val 0x01, rsp_ovf 1, ovf_total 1.
- LOAD 0x02, then DOWN len 3 -> rsp_val 0xFF, rsp_ovf 1 (underflow wrap).
- Push 5 commands back-to-back with FIFO_DEPTH 4 -> cmd_ready_out low after 4 accepts. Fifth is accepted once the first is popped. Responses arrive in order, spaced at least 4 cycles apart.
- UP len 0 -> en high for 1 cycle; response value = previous +1.
- Assert nrst_in=0 mid-burst (UP len 20, cycle 7) -> all outputs 0 asynchronously, FIFO empty, no rsp_valid pulse. With CNT_DRV_ABORT_EN, abort_in at cycle 3 of UP len 10 from 0x00 -> rsp_val 0x03.
